id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage for the 16-bit pipelined MIPS core. It captures decoded operands and control from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the 3-bit ALU opcode and the A/B operands straight into the EX-stage ALU. It also detects load-use hazards, requests an upstream stall, and counts inserted bubbles.

---
 rtl/core_pkg.sv | 16 +
 rtl/fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared widths, ALU opcodes and register constants for the 16-bit pipelined MIPS core.
package core_pkg;
    localparam int N    = 16;
    localparam int RA_W = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_GT  = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam logic [RA_W-1:0] R0 = '0;
endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB beats the registered register-file value.
module fwd_mux #(
    parameter int N    = core_pkg::N,
    parameter int RA_W = core_pkg::RA_W
) (
    input  logic [RA_W-1:0] src,
    input  logic [N-1:0]    reg_data,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [N-1:0]    exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [N-1:0]    memwb_result,
    output logic [N-1:0]    fwd_data
);
    import core_pkg::*;

    logic hit_exmem;
    logic hit_memwb;

    // r0 is hardwired zero, so a write to it must never be forwarded
    assign hit_exmem = exmem_reg_write && (exmem_rd != R0) && (exmem_rd == src);
    assign hit_memwb = memwb_reg_write && (memwb_rd != R0) && (memwb_rd == src);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem) begin
            fwd_data = exmem_result;
        end else if (hit_memwb) begin
            fwd_data = memwb_result;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall request and a saturating bubble counter.
module id_ex_stage #(
    parameter int N     = core_pkg::N,
    parameter int RA_W  = core_pkg::RA_W,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [2:0]      id_opcode,
    input  logic [N-1:0]    id_rs_data,
    input  logic [N-1:0]    id_rt_data,
    input  logic [N-1:0]    id_imm,
    input  logic            id_use_imm,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [N-1:0]    exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [N-1:0]    memwb_result,
    output logic            ex_valid,
    output logic [2:0]      ex_opcode,
    output logic [N-1:0]    ex_a,
    output logic [N-1:0]    ex_b,
    output logic [N-1:0]    ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            stall_req,
    output logic [CNT_W-1:0] bubble_cnt
);
    import core_pkg::*;

    logic             valid_q,     valid_d;
    logic [2:0]       opcode_q,    opcode_d;
    logic [N-1:0]     rs_data_q,   rs_data_d;
    logic [N-1:0]     rt_data_q,   rt_data_d;
    logic [N-1:0]     imm_q,       imm_d;
    logic             use_imm_q,   use_imm_d;
    logic [RA_W-1:0]  rs_q,        rs_d;
    logic [RA_W-1:0]  rt_q,        rt_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic [N-1:0] fwd_rs;
    logic [N-1:0] fwd_rt;

    assign ex_mem_read = valid_q & mem_read_q;

    assign stall_req = ex_mem_read && (rd_q != R0) && id_valid &&
                       ((id_rs == rd_q) || (id_uses_rt && (id_rt == rd_q)));

    always_comb begin
        valid_d      = valid_q;
        opcode_d     = opcode_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        use_imm_d    = use_imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (stall_req) begin
            valid_d = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else begin
            valid_d     = id_valid;
            opcode_d    = id_opcode;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            opcode_q     <= OP_ADD;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
            rs_q         <= R0;
            rt_q         <= R0;
            rd_q         <= R0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            opcode_q     <= opcode_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            use_imm_q    <= use_imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rs (
        .src             (rs_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs)
    );

    fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rt (
        .src             (rt_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rt)
    );

    assign ex_valid      = valid_q;
    assign ex_opcode     = opcode_q;
    assign ex_a          = fwd_rs;
    assign ex_b          = use_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_write  = valid_q & mem_write_q;
    assign bubble_cnt    = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for hazards, stall/flush, saturation and reset.
module tb_id_ex_stage;
    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [2:0]  id_opcode;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_uses_rt;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write;
    logic [2:0]  exmem_rd;
    logic [15:0] exmem_result;
    logic        memwb_reg_write;
    logic [2:0]  memwb_rd;
    logic [15:0] memwb_result;

    logic        ex_valid;
    logic [2:0]  ex_opcode;
    logic [15:0] ex_a, ex_b, ex_store_data;
    logic [2:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, stall_req;
    logic [15:0] bubble_cnt;

    logic        s_valid;
    logic [2:0]  s_opcode;
    logic [15:0] s_a, s_b, s_sd;
    logic [2:0]  s_rd;
    logic        s_rw, s_mr, s_mw, s_stall_req;
    logic [3:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_req(stall_req), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    id_ex_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(s_valid), .ex_opcode(s_opcode), .ex_a(s_a), .ex_b(s_b),
        .ex_store_data(s_sd), .ex_rd(s_rd), .ex_reg_write(s_rw),
        .ex_mem_read(s_mr), .ex_mem_write(s_mw),
        .stall_req(s_stall_req), .bubble_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [15:0] rs_d, rt_d, imm;
        logic        use_imm, uses_rt;
        logic [2:0]  rs, rt, rd;
        logic        rw, mw;
        logic        xrw;
        logic [2:0]  xrd;
        logic [15:0] xres;
        logic        mrw;
        logic [2:0]  mrd;
        logic [15:0] mres;
        logic        e_vld;
        logic [15:0] e_a, e_b, e_sd;
        logic        e_rw, e_mw;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0;
        id_valid = 0; id_opcode = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_use_imm = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ID holds "lw r4, 0(r1)"
    task automatic drive_load_r4();
        idle();
        id_valid = 1; id_opcode = 0; id_rs = 1; id_rt = 2; id_rd = 4;
        id_rs_data = 16'h0040; id_reg_write = 1; id_mem_read = 1;
    endtask

    // ID holds "add r6, r4, r5" (reads r4 through rs)
    task automatic drive_add_use_r4();
        idle();
        id_valid = 1; id_opcode = 0; id_rs = 4; id_rt = 5; id_rd = 6;
        id_uses_rt = 1; id_reg_write = 1;
    endtask

    initial begin
        vecs[0] = '{1, 0, 16'h0005, 16'h0003, 0, 0, 1, 1, 2, 3, 1, 0,
                    0, 0, 0, 0, 0, 0, 1, 16'h0005, 16'h0003, 16'h0003, 1, 0};
        vecs[1] = '{1, 1, 16'h0010, 16'h0007, 16'hFFF0, 1, 0, 1, 2, 5, 1, 0,
                    0, 0, 0, 0, 0, 0, 1, 16'h0010, 16'hFFF0, 16'h0007, 1, 0};
        vecs[2] = '{1, 2, 16'h1111, 16'h1234, 0, 0, 1, 2, 3, 6, 1, 0,
                    1, 2, 16'h00AA, 1, 2, 16'h00BB, 1, 16'h00AA, 16'h1234, 16'h1234, 1, 0};
        vecs[3] = '{1, 3, 16'h1111, 16'h1234, 0, 0, 1, 2, 3, 6, 1, 0,
                    1, 5, 16'h00AA, 1, 2, 16'h00BB, 1, 16'h00BB, 16'h1234, 16'h1234, 1, 0};
        vecs[4] = '{1, 4, 16'h0777, 16'h0101, 0, 0, 1, 0, 1, 2, 1, 0,
                    1, 0, 16'h00AA, 1, 0, 16'h00BB, 1, 16'h0777, 16'h0101, 16'h0101, 1, 0};
        vecs[5] = '{1, 5, 16'h0009, 16'h0001, 0, 0, 1, 1, 4, 7, 1, 0,
                    0, 4, 16'hCCCC, 1, 4, 16'h4444, 1, 16'h0009, 16'h4444, 16'h4444, 1, 0};
        vecs[6] = '{1, 6, 16'h0003, 16'h0005, 16'h0042, 1, 0, 2, 3, 1, 1, 0,
                    1, 3, 16'h3333, 1, 2, 16'h0200, 1, 16'h0200, 16'h0042, 16'h3333, 1, 0};
        vecs[7] = '{0, 7, 16'hAAAA, 16'h5555, 0, 0, 1, 1, 2, 3, 1, 1,
                    0, 0, 0, 0, 0, 0, 0, 16'hAAAA, 16'h5555, 16'h5555, 0, 0};
        vecs[8] = '{1, 0, 16'h0100, 16'hBEEF, 16'h0004, 1, 1, 1, 2, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'h0004, 16'hBEEF, 0, 1};

        idle();
        rst_n = 0;
        #12;
        chk("rst ex_valid", ex_valid, 0);
        chk("rst ex_a", ex_a, 0);
        chk("rst ex_b", ex_b, 0);
        chk("rst bubble_cnt", bubble_cnt, 0);
        chk("rst ex_reg_write", ex_reg_write, 0);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            id_valid = vecs[i].vld; id_opcode = vecs[i].op;
            id_rs_data = vecs[i].rs_d; id_rt_data = vecs[i].rt_d; id_imm = vecs[i].imm;
            id_use_imm = vecs[i].use_imm; id_uses_rt = vecs[i].uses_rt;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
            id_reg_write = vecs[i].rw; id_mem_read = 0; id_mem_write = vecs[i].mw;
            exmem_reg_write = vecs[i].xrw; exmem_rd = vecs[i].xrd; exmem_result = vecs[i].xres;
            memwb_reg_write = vecs[i].mrw; memwb_rd = vecs[i].mrd; memwb_result = vecs[i].mres;
            step();
            chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].e_vld);
            chk($sformatf("v%0d ex_opcode", i), ex_opcode, vecs[i].op);
            chk($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
            chk($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
            chk($sformatf("v%0d ex_store_data", i), ex_store_data, vecs[i].e_sd);
            chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].rd);
            chk($sformatf("v%0d ex_reg_write", i), ex_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d ex_mem_write", i), ex_mem_write, vecs[i].e_mw);
            chk($sformatf("v%0d ex_mem_read", i), ex_mem_read, 0);
            chk($sformatf("v%0d stall_req", i), stall_req, 0);
        end

        // load-use through rs: exactly one bubble
        drive_load_r4();
        step();
        chk("lu ex_mem_read", ex_mem_read, 1);
        drive_add_use_r4();
        #1;
        chk("lu stall_req", stall_req, 1);
        step();
        exp_cnt++;
        chk("lu bubble ex_valid", ex_valid, 0);
        chk("lu bubble ex_reg_write", ex_reg_write, 0);
        chk("lu bubble_cnt", bubble_cnt, exp_cnt);
        chk("lu stall_req drop", stall_req, 0);
        step();
        chk("lu resume ex_valid", ex_valid, 1);
        chk("lu resume ex_rd", ex_rd, 6);

        // store reading r4 through rt
        drive_load_r4();
        step();
        idle();
        id_valid = 1; id_rs = 1; id_rt = 4; id_uses_rt = 1; id_mem_write = 1; id_use_imm = 1;
        #1;
        chk("store rt stall_req", stall_req, 1);
        step();
        exp_cnt++;
        chk("store bubble_cnt", bubble_cnt, exp_cnt);
        drive_load_r4();
        step();
        idle();
        id_valid = 1; id_rs = 1; id_rt = 4; id_uses_rt = 0; id_use_imm = 1; id_reg_write = 1;
        #1;
        chk("imm no stall_req", stall_req, 0);

        // flush and stall together over a pending hazard: bubble, no count
        drive_load_r4();
        step();
        drive_add_use_r4();
        flush = 1; stall = 1;
        step();
        chk("flush+stall ex_valid", ex_valid, 0);
        chk("flush+stall bubble_cnt", bubble_cnt, exp_cnt);

        // stall and hazard together: stall wins, hazard taken next cycle
        drive_load_r4();
        step();
        drive_add_use_r4();
        stall = 1;
        step();
        chk("stall+hz ex_valid", ex_valid, 1);
        chk("stall+hz ex_mem_read", ex_mem_read, 1);
        chk("stall+hz bubble_cnt", bubble_cnt, exp_cnt);
        chk("stall+hz stall_req", stall_req, 1);
        stall = 0;
        step();
        exp_cnt++;
        chk("post-stall bubble ex_valid", ex_valid, 0);
        chk("post-stall bubble_cnt", bubble_cnt, exp_cnt);

        // three-cycle stall holds everything
        idle();
        id_valid = 1; id_opcode = 3; id_rs = 1; id_rt = 2; id_rd = 5; id_uses_rt = 1;
        id_rs_data = 16'h1357; id_rt_data = 16'h2468; id_reg_write = 1;
        step();
        for (int c = 0; c < 3; c++) begin
            stall = 1;
            id_opcode = 7; id_rs_data = 16'hFFFF; id_rt_data = 16'hEEEE; id_rd = 2; id_valid = c[0];
            step();
            chk($sformatf("hold%0d ex_a", c), ex_a, 16'h1357);
            chk($sformatf("hold%0d ex_b", c), ex_b, 16'h2468);
            chk($sformatf("hold%0d ex_opcode", c), ex_opcode, 3);
            chk($sformatf("hold%0d ex_rd", c), ex_rd, 5);
            chk($sformatf("hold%0d ex_valid", c), ex_valid, 1);
        end

        // saturation on the 4-bit copy; wide copy keeps counting
        for (int k = 0; k < 17; k++) begin
            drive_load_r4();
            step();
            drive_add_use_r4();
            step();
            exp_cnt++;
        end
        chk("sat wide bubble_cnt", bubble_cnt, exp_cnt);
        chk("sat narrow bubble_cnt", s_cnt, 15);
        drive_load_r4();
        step();
        drive_add_use_r4();
        step();
        exp_cnt++;
        chk("sat narrow hold", s_cnt, 15);
        chk("sat wide next", bubble_cnt, exp_cnt);

        // async reset mid-cycle while stalled with a load in EX
        drive_load_r4();
        id_rs_data = 16'h0F0F;
        step();
        drive_add_use_r4();
        stall = 1;
        #2;
        rst_n = 0;
        #1;
        chk("arst ex_valid", ex_valid, 0);
        chk("arst ex_a", ex_a, 0);
        chk("arst ex_rd", ex_rd, 0);
        chk("arst ex_mem_read", ex_mem_read, 0);
        chk("arst stall_req", stall_req, 0);
        chk("arst bubble_cnt", bubble_cnt, 0);
        chk("arst narrow bubble_cnt", s_cnt, 0);
        idle();
        step();
        rst_n = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
